// File: rtl/mult_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit with HI/LO result registers (shift-add / restoring divide).
// Define MULTDIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               op_q,      op_d;
  logic               neg_q,     neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0]   dvs_q,     dvs_d;
  logic [WIDTH:0]     rem_q,     rem_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               dz_q,      dz_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;

  logic signed_op;

`ifdef MULTDIV_SIGNED_EN
  assign signed_op = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign signed_op        = 1'b0;
`endif

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_abs = a_neg ? (-a) : a;
  assign b_abs = b_neg ? (-b) : b;

  // Multiply: acc holds {partial product, remaining multiplier bits}; dvs holds the multiplicand.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ok;

  assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};
  assign div_ok    = ~div_diff[WIDTH];

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q     ? (-acc_q)            : acc_q;
  assign quo_fix  = neg_q     ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvs_d     = op ? b_abs : a_abs;
          acc_d     = {{WIDTH{1'b0}}, (op ? a_abs : b_abs)};
          rem_d     = '0;
          cnt_d     = '0;
          if (op && (b == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
          rem_d = div_ok ? div_diff : div_shift;
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
